adder_bcd_display_nbit: RTL
===========================

Name: adder_bcd_display_nbit

Overview:
- Parametrised two-operand add/subtract unit with registered operands, loaded from shared switches by active-low push-keys.
- Optional accumulate mode feeds the result back into operand A.
- The result is presented as raw hex nibbles or as BCD digits. BCD comes from a multi-cycle shift-add-3 (double-dabble) converter.
- Sits between board switches/keys and the 7-segment digit decoders. It generalises the fixed 8-bit adder/display datapath in width, digit count and mode.

Parameters:
- W, 8, operand width in bits.
- DIGITS, 4, number of 4-bit output digits. Constraints: 4*DIGITS >= W+1 and 10^DIGITS > 2^(W+1)-1. Violation is a simulation $error at elaboration.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- data_in  in  W  operand value from switches.
- load_a_n  in  1  raw active-low key; press loads operand A.
- load_b_n  in  1  raw active-low key; press loads operand B.
- acc_en  in  1  1: a load_a press loads A from result[W-1:0] instead of data_in.
- sub  in  1  0: add, 1: subtract.
- cin  in  1  carry-in; add mode only.
- dec_mode  in  1  0: hex display, 1: decimal display.
- a_q  out  W  operand A register.
- b_q  out  W  operand B register.
- result  out  W+1  registered result.
- neg  out  1  subtract result negative; result holds magnitude.
- digits  out  4*DIGITS  display digits; digit 0 in [3:0].
- busy  out  1  BCD conversion in progress.
- valid  out  1  digits match current result and dec_mode.

Behaviour:

Reset (async, Resetn=0):
- a_q, b_q, result, digits = 0; neg = 0; busy = 0; valid = 1.
- FSM = IDLE; key synchroniser flops = 1 (released).

Keys:
- Each key passes a 2-flop synchroniser, then a falling-edge detect, giving a one-cycle press pulse.
- A key held low gives exactly one pulse. No debounce.

Loads:
- On a press pulse, the register updates at that edge.
- A <= acc_en ? result[W-1:0] : data_in.
- B <= data_in.
- Simultaneous A and B pulses load both.

Arithmetic (registered one cycle after any change of a_q, b_q, sub, cin):
- Add: result = A + B + cin, zero-extended to W+1; neg = 0.
- Sub: if A >= B, result = A - B, neg = 0; else result = B - A, neg = 1. cin is ignored.

Converter start:
- Triggered by any change of result or dec_mode, as a registered compare against previous values.
- On start: valid = 0.

Hex path (dec_mode=0):
- Cycle after start: digits = zero-extended result; valid = 1; busy stays 0.

Dec path (dec_mode=1), FSM IDLE -> SHIFT -> DONE -> IDLE:
- SHIFT: W+1 cycles, one result bit per cycle, MSB first. Before each shift, every BCD nibble >= 5 gets +3. busy = 1.
- DONE: one cycle; digits <= BCD register; valid = 1; busy = 0.
- Latency from result change to valid: W+3 cycles (11 for W=8).

Conversion boundaries:
- A new trigger during SHIFT or DONE aborts and restarts from the first shift. digits keep their old value until the restarted conversion finishes.
- A dec_mode change mid-conversion is treated as a restart.
- Reset mid-conversion: immediate return to reset values.

Test Plan:
- Reset, then release -> a_q=b_q=0, result=0, digits=0x0000, valid=1, busy=0.
- W=8. data_in=200, press A; data_in=100, press B; sub=0, cin=0, dec_mode=0 -> result=0x12C, digits=0x012C. Then dec_mode=1 -> busy for 9 cycles, then digits=0x0300, valid=1.
- A=5, B=9, sub=1 -> result=4, neg=1, digits 0x0004. Then cin=1 -> unchanged.
- A=1, B=1, add, acc_en=1, three load_a presses -> a_q = 2, 3, 4; result = 5.
- load_a_n held low 1000 cycles -> exactly one load. Press both keys in the same cycle with data_in=0x3C -> a_q = b_q = 0x3C.
- Dec conversion in progress: change B at SHIFT cycle 4 -> restart, final digits match the new sum. Resetn=0 at SHIFT cycle 6 -> busy=0, digits=0 immediately.

Source files
------------

// File: rtl/adder_bcd_display_nbit_if.sv
// Switch/key inputs and display-side outputs of the add/subtract display unit.
// The master modport drives the board side, the slave modport is the datapath.
interface adder_bcd_display_nbit_if #(
    parameter int W      = 8,
    parameter int DIGITS = 4
);
    logic [W-1:0]          data_in;
    logic                  load_a_n;
    logic                  load_b_n;
    logic                  acc_en;
    logic                  sub;
    logic                  cin;
    logic                  dec_mode;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic [W:0]            result;
    logic                  neg;
    logic [4*DIGITS-1:0]   digits;
    logic                  busy;
    logic                  valid;

    modport master (
        output data_in, load_a_n, load_b_n, acc_en, sub, cin, dec_mode,
        input  a_q, b_q, result, neg, digits, busy, valid
    );

    modport slave (
        input  data_in, load_a_n, load_b_n, acc_en, sub, cin, dec_mode,
        output a_q, b_q, result, neg, digits, busy, valid
    );
endinterface

// File: rtl/adder_bcd_display_nbit.sv
// Key-loaded add/subtract unit with registered result and a hex or
// double-dabble BCD display path.
//
// state | meaning
// IDLE  | digits stable, waiting for a result or display-mode change
// SHIFT | double-dabble: adjust nibbles >= 5 by +3, shift in one result bit
// DONE  | publish converted (or hex) value to digits, raise valid
module adder_bcd_display_nbit #(
    parameter int W      = 8,
    parameter int DIGITS = 4
) (
    input  logic Clock,
    input  logic Resetn,
    adder_bcd_display_nbit_if.slave bus
);
    localparam int DW = 4 * DIGITS;
    localparam int RW = W + 1;
    localparam int CW = $clog2(W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_RESULT = (longint'(1) << RW) - 1;

    generate
        if ((DW < RW) || (pow10(DIGITS) <= MAX_RESULT)) begin : g_param_err
            $error("adder_bcd_display_nbit: DIGITS=%0d too small for W=%0d", DIGITS, W);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ka_q, kb_q;
    logic [W-1:0]    a_q, b_q;
    logic [RW-1:0]   res_q, res_d, prev_res_q;
    logic            neg_q, neg_d, prev_mode_q;
    logic [DW-1:0]   digits_q, digits_d, bcd_q, bcd_d, bcd_adj;
    logic [RW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            press_a, press_b, start;
    logic [W-1:0]    diff_ab, diff_ba;

    // Bit 1 is the synchronised key, bit 2 its previous value.
    assign press_a = ka_q[2] & ~ka_q[1];
    assign press_b = kb_q[2] & ~kb_q[1];
    assign start   = (res_q != prev_res_q) || (bus.dec_mode != prev_mode_q);
    assign diff_ab = a_q - b_q;
    assign diff_ba = b_q - a_q;

    always_comb begin
        res_d = {1'b0, a_q} + {1'b0, b_q} + RW'(bus.cin);
        neg_d = 1'b0;
        if (bus.sub) begin
            if (a_q >= b_q) begin
                res_d = {1'b0, diff_ab};
            end else begin
                res_d = {1'b0, diff_ba};
                neg_d = 1'b1;
            end
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        // A trigger in any state restarts; digits hold until the new value lands.
        if (start) begin
            valid_d = 1'b0;
            if (bus.dec_mode) begin
                state_d = SHIFT;
                bcd_d   = '0;
                sr_d    = res_q;
                cnt_d   = CW'(W);
            end else begin
                state_d = DONE;
                bcd_d   = DW'(res_q);
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    bcd_d = {bcd_adj[DW-2:0], sr_q[RW-1]};
                    sr_d  = {sr_q[RW-2:0], 1'b0};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = DONE;
                end
                DONE: begin
                    digits_d = bcd_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ka_q        <= '1;
            kb_q        <= '1;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            neg_q       <= 1'b0;
            prev_res_q  <= '0;
            prev_mode_q <= 1'b0;
            digits_q    <= '0;
            bcd_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b1;
        end else begin
            ka_q        <= {ka_q[1:0], bus.load_a_n};
            kb_q        <= {kb_q[1:0], bus.load_b_n};
            if (press_a) a_q <= bus.acc_en ? res_q[W-1:0] : bus.data_in;
            if (press_b) b_q <= bus.data_in;
            res_q       <= res_d;
            neg_q       <= neg_d;
            prev_res_q  <= res_q;
            prev_mode_q <= bus.dec_mode;
            digits_q    <= digits_d;
            bcd_q       <= bcd_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.a_q    = a_q;
    assign bus.b_q    = b_q;
    assign bus.result = res_q;
    assign bus.neg    = neg_q;
    assign bus.digits = digits_q;
    assign bus.busy   = (state_q == SHIFT);
    assign bus.valid  = valid_q;
endmodule
